// File: rtl/io_pkg.sv
// -----------------------------------------------------------------------------
// io_pkg
// Shared types and constants for the I/O write poster and its FIFO.
//   PW_DEPTH_DEF : default number of posted-write entries
//   pw_entry_t   : one posted write {address, data, upper/lower strobes}
//   io_state_t   : state of the IOB-side sequencer
// -----------------------------------------------------------------------------
package io_pkg;

   localparam int PW_DEPTH_DEF = 2;

   // 41-bit posted-write entry; the write strobe is implicit (always a write).
   typedef struct packed {
      logic [23:1] a;
      logic [15:0] d;
      logic        nuds;
      logic        nlds;
   } pw_entry_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      POSTED = 2'd1,
      DIRECT = 2'd2
   } io_state_t;

endpackage : io_pkg

// File: rtl/pw_fifo.sv
// -----------------------------------------------------------------------------
// pw_fifo
// Synchronous FIFO holding posted CPU writes until the IOB sequencer drains
// them. DEPTH must be a power of two (at least 2) so the pointers wrap
// naturally.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push_i     : enqueue entry_i (ignored while full)
//   entry_i    : entry to enqueue
//   pop_i      : dequeue the head entry (ignored while empty)
//   head_o     : oldest entry
//   count_o    : number of valid entries, 0..DEPTH
//   empty_o    : registered (count == 0)
//   full_o     : registered (count == DEPTH)
// -----------------------------------------------------------------------------
module pw_fifo
   import io_pkg::*;
#(
   parameter int DEPTH = PW_DEPTH_DEF
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push_i,
   input  pw_entry_t                    entry_i,
   input  logic                         pop_i,
   output pw_entry_t                    head_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o,
   output logic                         empty_o,
   output logic                         full_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

   pw_entry_t     mem_q [DEPTH];
   logic [PW-1:0] wptr_q;
   logic [PW-1:0] rptr_q;
   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;
   logic          empty_q;
   logic          full_q;
   logic          do_push;
   logic          do_pop;

   assign do_push = push_i && !full_q;
   assign do_pop  = pop_i && !empty_q;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      count_d = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;   // idle, or push+pop: count unchanged
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so all
   // registers update together from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
      end else begin
         if (do_push) wptr_q <= wptr_q + PW'(1);
         if (do_pop)  rptr_q <= rptr_q + PW'(1);
         count_q <= count_d;
         empty_q <= (count_d == '0);
         full_q  <= (count_d == FULL_C);
      end
   end

   // NOTE: the storage array is deliberately not reset; validity is defined
   // entirely by the pointers and count, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= entry_i;
   end

   assign head_o  = mem_q[rptr_q];
   assign count_o = count_q;
   assign empty_o = empty_q;
   assign full_o  = full_q;

endmodule : pw_fifo

// File: rtl/io_write_poster.sv
// -----------------------------------------------------------------------------
// io_write_poster
// Sits between the chip-select decoder and the slow I/O bus (IOB) sequencer.
// Post-write-eligible CPU writes are queued and acknowledged immediately; all
// other IOB-domain cycles wait until the queue drains, then go to the IOB
// directly, so writes are never reordered. The IOB sees one request at a time.
// Ports:
//   CLK, nRES        : clock, asynchronous active-low reset
//   A, D, nWE        : CPU address [23:1], write data, write strobe
//   nUDS, nLDS       : CPU data strobes
//   BACT             : CPU bus cycle active
//   IOCS, IOPWCS     : decoder selects (IOB domain, post-write eligible)
//   CPUACK           : terminates the CPU cycle
//   IOREQ, IOA, IOD  : IOB request, address, write data
//   IOnWE/IOnUDS/IOnLDS : IOB strobes
//   IOACK            : one-cycle IOB completion pulse
//   PWEmpty, PWFull  : queue status
// -----------------------------------------------------------------------------
module io_write_poster
   import io_pkg::*;
#(
   parameter int DEPTH = PW_DEPTH_DEF
) (
   input  logic        CLK,
   input  logic        nRES,
   input  logic [23:1] A,
   input  logic [15:0] D,
   input  logic        nWE,
   input  logic        nUDS,
   input  logic        nLDS,
   input  logic        BACT,
   input  logic        IOCS,
   input  logic        IOPWCS,
   output logic        CPUACK,
   output logic        IOREQ,
   output logic [23:1] IOA,
   output logic [15:0] IOD,
   output logic        IOnWE,
   output logic        IOnUDS,
   output logic        IOnLDS,
   input  logic        IOACK,
   output logic        PWEmpty,
   output logic        PWFull
);

   localparam int CW = $clog2(DEPTH + 1);

   // Queue interface
   pw_entry_t     pw_in;
   pw_entry_t     pw_head;
   logic [CW-1:0] pw_count;
   logic          pw_empty;
   logic          pw_full;
   logic          pw_push;
   logic          pw_pop;

   // CPU-side acceptance
   logic          posted_elig;
   logic          direct_elig;
   logic          dir_done;
   logic          accept;
   logic          handled_q, handled_d;
   logic          cpuack_q,  cpuack_d;
   logic          dirpend_q, dirpend_d;

   // IOB-side sequencer
   io_state_t     state_q;
   logic          ioreq_q;
   logic [23:1]   ioa_q;
   logic [15:0]   iod_q;
   logic          ionwe_q;
   logic          ionuds_q;
   logic          ionlds_q;

   assign pw_in.a    = A;
   assign pw_in.d    = D;
   assign pw_in.nuds = nUDS;
   assign pw_in.nlds = nLDS;

   pw_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (CLK),
      .rst_n   (nRES),
      .push_i  (pw_push),
      .entry_i (pw_in),
      .pop_i   (pw_pop),
      .head_o  (pw_head),
      .count_o (pw_count),
      .empty_o (pw_empty),
      .full_o  (pw_full)
   );

   // ---------------------------------------------------------------------------
   // CPU-side acceptance. handled_q makes each bus cycle act at most once; it
   // and CPUACK both drop on the edge that samples BACT low.
   // ---------------------------------------------------------------------------
   always_comb begin
      posted_elig = BACT && IOCS && IOPWCS && !nWE && !handled_q;
      direct_elig = BACT && IOCS && !handled_q && !(IOPWCS && !nWE);
      pw_push     = posted_elig && !pw_full;
      pw_pop      = (state_q == POSTED) && IOACK;
      dir_done    = (state_q == DIRECT) && IOACK;
      // A direct completion after BACT has fallen is not acknowledged.
      accept      = pw_push || (dir_done && BACT);

      handled_d   = BACT && (handled_q || accept);
      cpuack_d    = BACT && (cpuack_q  || accept);

      dirpend_d   = dirpend_q;
      if (dir_done) begin
         dirpend_d = 1'b0;
      end else if (direct_elig) begin
         dirpend_d = 1'b1;
      end else if (!BACT && (state_q != DIRECT)) begin
         // Cycle abandoned before the IOB picked it up: drop the request
         // rather than issue it later with someone else's address.
         dirpend_d = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge nRES) begin
      if (!nRES) begin
         handled_q <= 1'b0;
         cpuack_q  <= 1'b0;
         dirpend_q <= 1'b0;
      end else begin
         handled_q <= handled_d;
         cpuack_q  <= cpuack_d;
         dirpend_q <= dirpend_d;
      end
   end

   // ---------------------------------------------------------------------------
   // IOB sequencer. Queued writes always go first; a direct cycle is only
   // started once the queue is empty. Every transaction returns through IDLE,
   // which guarantees one idle cycle between requests, and the IOB-side
   // address/data/strobes are loaded only on entry so they stay stable for
   // the whole request.
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLK or negedge nRES) begin
      if (!nRES) begin
         state_q  <= IDLE;
         ioreq_q  <= 1'b0;
         ioa_q    <= '0;
         iod_q    <= '0;
         ionwe_q  <= 1'b1;
         ionuds_q <= 1'b1;
         ionlds_q <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (pw_count != '0) begin
                  state_q  <= POSTED;
                  ioreq_q  <= 1'b1;
                  ioa_q    <= pw_head.a;
                  iod_q    <= pw_head.d;
                  ionwe_q  <= 1'b0;
                  ionuds_q <= pw_head.nuds;
                  ionlds_q <= pw_head.nlds;
               end else if (dirpend_q && BACT) begin
                  state_q  <= DIRECT;
                  ioreq_q  <= 1'b1;
                  ioa_q    <= A;
                  iod_q    <= D;
                  ionwe_q  <= nWE;
                  ionuds_q <= nUDS;
                  ionlds_q <= nLDS;
               end
            end
            POSTED, DIRECT: begin
               if (IOACK) begin
                  state_q <= IDLE;
                  ioreq_q <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               ioreq_q <= 1'b0;
            end
         endcase
      end
   end

   assign CPUACK  = cpuack_q;
   assign IOREQ   = ioreq_q;
   assign IOA     = ioa_q;
   assign IOD     = iod_q;
   assign IOnWE   = ionwe_q;
   assign IOnUDS  = ionuds_q;
   assign IOnLDS  = ionlds_q;
   assign PWEmpty = pw_empty;
   assign PWFull  = pw_full;

endmodule : io_write_poster

// File: tb/tb_io_write_poster.sv
// -----------------------------------------------------------------------------
// tb_io_write_poster
// Directed bench for io_write_poster (DEPTH = 2). Inputs change 1 time unit
// after a rising edge; outputs are observed at the same point, i.e. they show
// the result of the edge just taken.
// -----------------------------------------------------------------------------
module tb_io_write_poster;

   logic        CLK = 1'b0;
   logic        nRES;
   logic [23:1] A;
   logic [15:0] D;
   logic        nWE, nUDS, nLDS, BACT, IOCS, IOPWCS, IOACK;
   logic        CPUACK, IOREQ, IOnWE, IOnUDS, IOnLDS, PWEmpty, PWFull;
   logic [23:1] IOA;
   logic [15:0] IOD;

   int nv = 0;   // vectors applied
   int ne = 0;   // miscompares

   always #5 CLK = ~CLK;

   io_write_poster #(.DEPTH(2)) dut (
      .CLK     (CLK),
      .nRES    (nRES),
      .A       (A),
      .D       (D),
      .nWE     (nWE),
      .nUDS    (nUDS),
      .nLDS    (nLDS),
      .BACT    (BACT),
      .IOCS    (IOCS),
      .IOPWCS  (IOPWCS),
      .CPUACK  (CPUACK),
      .IOREQ   (IOREQ),
      .IOA     (IOA),
      .IOD     (IOD),
      .IOnWE   (IOnWE),
      .IOnUDS  (IOnUDS),
      .IOnLDS  (IOnLDS),
      .IOACK   (IOACK),
      .PWEmpty (PWEmpty),
      .PWFull  (PWFull)
   );

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic bus_idle();
      BACT = 1'b0; IOCS = 1'b0; IOPWCS = 1'b0; nWE = 1'b1;
      nUDS = 1'b1; nLDS = 1'b1; A = '0; D = '0;
   endtask

   task automatic post_cycle(input logic [23:1] a, input logic [15:0] d);
      BACT = 1'b1; IOCS = 1'b1; IOPWCS = 1'b1; nWE = 1'b0;
      nUDS = 1'b0; nLDS = 1'b0; A = a; D = d;
   endtask

   task automatic test_reset();
      nRES = 1'b0; IOACK = 1'b0; bus_idle();
      step(); step();
      nv++; if ({CPUACK, IOREQ, IOA, IOD} !== 41'h0) begin ne++;
         $display("FAIL reset_zero: got %h want 0", {CPUACK, IOREQ, IOA, IOD}); end
      nv++; if ({IOnWE, IOnUDS, IOnLDS, PWEmpty, PWFull} !== 5'b11110) begin ne++;
         $display("FAIL reset_ones: got %b want 11110", {IOnWE, IOnUDS, IOnLDS, PWEmpty, PWFull}); end
      nRES = 1'b1;
      step();
      nv++; if ({CPUACK, IOREQ, PWEmpty, PWFull} !== 4'b0010) begin ne++;
         $display("FAIL reset_release: got %b want 0010", {CPUACK, IOREQ, PWEmpty, PWFull}); end
   endtask

   task automatic test_single_post();
      post_cycle(23'h1FD080, 16'h1234);
      step();                                   // edge k: enqueue
      nv++; if ({CPUACK, IOREQ, PWEmpty} !== 3'b100) begin ne++;
         $display("FAIL single_ack: got %b want 100", {CPUACK, IOREQ, PWEmpty}); end
      bus_idle();
      step();                                   // edge k+1: request issued
      nv++; if ({IOREQ, IOA, IOD, IOnWE, IOnUDS, IOnLDS} !== {1'b1, 23'h1FD080, 16'h1234, 3'b000}) begin ne++;
         $display("FAIL single_req: got %h want %h", {IOREQ, IOA, IOD, IOnWE, IOnUDS, IOnLDS},
                  {1'b1, 23'h1FD080, 16'h1234, 3'b000}); end
      nv++; if (CPUACK !== 1'b0) begin ne++;
         $display("FAIL single_ack_drop: got %b want 0", CPUACK); end
      IOACK = 1'b1; step(); IOACK = 1'b0;
      nv++; if ({IOREQ, PWEmpty} !== 2'b01) begin ne++;
         $display("FAIL single_drain: got %b want 01", {IOREQ, PWEmpty}); end
      step();
      nv++; if (IOREQ !== 1'b0) begin ne++;
         $display("FAIL single_no_repeat: got %b want 0", IOREQ); end
   endtask

   task automatic test_back_to_back();
      post_cycle(23'h000100, 16'h1111); step();
      nv++; if (CPUACK !== 1'b1) begin ne++;
         $display("FAIL b2b_ack1: got %b want 1", CPUACK); end
      bus_idle(); step();
      post_cycle(23'h000200, 16'h2222); step();
      nv++; if ({CPUACK, PWFull, IOREQ, IOA} !== {3'b111, 23'h000100}) begin ne++;
         $display("FAIL b2b_ack2_full: got %h want %h", {CPUACK, PWFull, IOREQ, IOA}, {3'b111, 23'h000100}); end
      bus_idle(); step();
      post_cycle(23'h000300, 16'h3333); step(); step();
      nv++; if ({CPUACK, PWFull} !== 2'b01) begin ne++;
         $display("FAIL b2b_stall: got %b want 01", {CPUACK, PWFull}); end
      IOACK = 1'b1; step(); IOACK = 1'b0;
      nv++; if ({CPUACK, IOREQ, PWFull} !== 3'b000) begin ne++;
         $display("FAIL b2b_dequeue: got %b want 000", {CPUACK, IOREQ, PWFull}); end
      step();
      nv++; if ({CPUACK, PWFull, IOREQ, IOA, IOD} !== {3'b111, 23'h000200, 16'h2222}) begin ne++;
         $display("FAIL b2b_ack3: got %h want %h", {CPUACK, PWFull, IOREQ, IOA, IOD},
                  {3'b111, 23'h000200, 16'h2222}); end
      bus_idle(); IOACK = 1'b1; step(); IOACK = 1'b0;
      step();
      nv++; if ({IOREQ, IOA, IOD} !== {1'b1, 23'h000300, 16'h3333}) begin ne++;
         $display("FAIL b2b_third_req: got %h want %h", {IOREQ, IOA, IOD}, {1'b1, 23'h000300, 16'h3333}); end
      IOACK = 1'b1; step(); IOACK = 1'b0;
      nv++; if ({IOREQ, PWEmpty, CPUACK} !== 3'b010) begin ne++;
         $display("FAIL b2b_drain: got %b want 010", {IOREQ, PWEmpty, CPUACK}); end
   endtask

   task automatic test_read_after_post();
      post_cycle(23'h000800, 16'hABCD); step();
      bus_idle(); step();
      // IOCS read of byte address E00000
      BACT = 1'b1; IOCS = 1'b1; IOPWCS = 1'b0; nWE = 1'b1;
      nUDS = 1'b0; nLDS = 1'b0; A = 23'h700000; D = 16'h0000;
      step(); step();
      nv++; if ({CPUACK, IOREQ, IOA} !== {2'b01, 23'h000800}) begin ne++;
         $display("FAIL rd_waits: got %h want %h", {CPUACK, IOREQ, IOA}, {2'b01, 23'h000800}); end
      IOACK = 1'b1; step(); IOACK = 1'b0;
      nv++; if ({IOREQ, PWEmpty, CPUACK} !== 3'b010) begin ne++;
         $display("FAIL rd_post_done: got %b want 010", {IOREQ, PWEmpty, CPUACK}); end
      step();
      nv++; if ({IOREQ, IOA, IOnWE, IOnUDS, IOnLDS, CPUACK} !== {1'b1, 23'h700000, 4'b1000}) begin ne++;
         $display("FAIL rd_req: got %h want %h", {IOREQ, IOA, IOnWE, IOnUDS, IOnLDS, CPUACK},
                  {1'b1, 23'h700000, 4'b1000}); end
      IOACK = 1'b1; step(); IOACK = 1'b0;
      nv++; if ({IOREQ, CPUACK} !== 2'b01) begin ne++;
         $display("FAIL rd_ack: got %b want 01", {IOREQ, CPUACK}); end
      step();
      nv++; if ({IOREQ, CPUACK} !== 2'b01) begin ne++;
         $display("FAIL rd_once: got %b want 01", {IOREQ, CPUACK}); end
      bus_idle(); step();
      nv++; if ({IOREQ, CPUACK} !== 2'b00) begin ne++;
         $display("FAIL rd_end: got %b want 00", {IOREQ, CPUACK}); end
   endtask

   task automatic test_simul_enq_deq();
      logic [23:1] a_i;
      logic [15:0] d_i;
      post_cycle(23'h000010, 16'hA000); step();
      bus_idle(); step();
      nv++; if ({IOREQ, IOA, IOD} !== {1'b1, 23'h000010, 16'hA000}) begin ne++;
         $display("FAIL sim_first: got %h want %h", {IOREQ, IOA, IOD}, {1'b1, 23'h000010, 16'hA000}); end
      for (int i = 1; i <= 4; i++) begin
         a_i = 23'h000010 + 23'(i);
         d_i = 16'hA000 + 16'(i);
         post_cycle(a_i, d_i); IOACK = 1'b1; step(); IOACK = 1'b0;
         nv++; if ({CPUACK, IOREQ, PWEmpty, PWFull} !== 4'b1000) begin ne++;
            $display("FAIL sim_count_iter%0d: got %b want 1000", i, {CPUACK, IOREQ, PWEmpty, PWFull}); end
         bus_idle(); step();
         nv++; if ({IOREQ, IOA, IOD} !== {1'b1, a_i, d_i}) begin ne++;
            $display("FAIL sim_order_iter%0d: got %h want %h", i, {IOREQ, IOA, IOD}, {1'b1, a_i, d_i}); end
      end
      IOACK = 1'b1; step(); IOACK = 1'b0;
      nv++; if ({IOREQ, PWEmpty} !== 2'b01) begin ne++;
         $display("FAIL sim_drain: got %b want 01", {IOREQ, PWEmpty}); end
   endtask

   task automatic test_reset_mid();
      post_cycle(23'h000400, 16'h4444); step();
      bus_idle(); step();
      post_cycle(23'h000500, 16'h5555); step();
      nv++; if ({IOREQ, PWFull, CPUACK} !== 3'b111) begin ne++;
         $display("FAIL rst_setup: got %b want 111", {IOREQ, PWFull, CPUACK}); end
      #2 nRES = 1'b0;
      #1;
      nv++; if ({IOREQ, CPUACK, PWEmpty, PWFull} !== 4'b0010) begin ne++;
         $display("FAIL rst_async: got %b want 0010", {IOREQ, CPUACK, PWEmpty, PWFull}); end
      nv++; if ({IOA, IOD, IOnWE, IOnUDS, IOnLDS} !== {39'h0, 3'b111}) begin ne++;
         $display("FAIL rst_async_bus: got %h want %h", {IOA, IOD, IOnWE, IOnUDS, IOnLDS}, {39'h0, 3'b111}); end
      bus_idle(); step();
      nRES = 1'b1;
      IOACK = 1'b1; step(); IOACK = 1'b0;
      nv++; if ({IOREQ, CPUACK, PWEmpty, PWFull} !== 4'b0010) begin ne++;
         $display("FAIL rst_spurious_ack: got %b want 0010", {IOREQ, CPUACK, PWEmpty, PWFull}); end
      step();
      nv++; if (IOREQ !== 1'b0) begin ne++;
         $display("FAIL rst_discard: got %b want 0", IOREQ); end
   endtask

   task automatic test_ignore();
      bus_idle();
      BACT = 1'b1; IOCS = 1'b0; IOPWCS = 1'b1; nWE = 1'b0;
      nUDS = 1'b0; nLDS = 1'b0; A = 23'h000000; D = 16'hFFFF;
      step(); step(); step();
      nv++; if ({CPUACK, IOREQ, PWEmpty, PWFull} !== 4'b0010) begin ne++;
         $display("FAIL ign_noniocs: got %b want 0010", {CPUACK, IOREQ, PWEmpty, PWFull}); end
      bus_idle(); IOACK = 1'b1; step(); IOACK = 1'b0;
      nv++; if ({CPUACK, IOREQ, PWEmpty, PWFull} !== 4'b0010) begin ne++;
         $display("FAIL ign_idle_ack: got %b want 0010", {CPUACK, IOREQ, PWEmpty, PWFull}); end
      post_cycle(23'h000600, 16'h6666); step();
      nv++; if (CPUACK !== 1'b1) begin ne++;
         $display("FAIL ign_after_ack: got %b want 1", CPUACK); end
      bus_idle(); step();
      nv++; if ({IOREQ, IOA, IOD} !== {1'b1, 23'h000600, 16'h6666}) begin ne++;
         $display("FAIL ign_after_req: got %h want %h", {IOREQ, IOA, IOD}, {1'b1, 23'h000600, 16'h6666}); end
      IOACK = 1'b1; step(); IOACK = 1'b0;
      nv++; if ({IOREQ, PWEmpty} !== 2'b01) begin ne++;
         $display("FAIL ign_drain: got %b want 01", {IOREQ, PWEmpty}); end
   endtask

   initial begin
      test_reset();
      test_single_post();
      test_back_to_back();
      test_read_after_post();
      test_simul_enq_deq();
      test_reset_mid();
      test_ignore();
      $display("== %0d vectors applied, %0d miscompares ==", nv, ne);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule : tb_io_write_poster

// File: doc/io_write_poster.md
Name: io_write_poster

Overview:
- Sits directly downstream of the chip-select decoder and upstream of the slow I/O bus (IOB) sequencer.
- Consumes IOCS/IOPWCS for each CPU bus cycle. Eligible writes are posted into a small FIFO and acknowledged to the CPU at once.
- All other IOCS cycles are forwarded to IOB only after the FIFO drains, which preserves write ordering.
- IOB sees one request at a time: FIFO entries first, then the direct CPU cycle.

Parameters:
- DEPTH, 2, number of posted-write entries (power of two, at least 2).

Ports:
- CLK  in  1  system clock; all state on rising edge
- nRES  in  1  reset, asynchronous assert, active-low; clears all state
- A  in  23  CPU address [23:1]
- D  in  16  CPU write data
- nWE  in  1  CPU write strobe, low = write
- nUDS  in  1  CPU upper data strobe
- nLDS  in  1  CPU lower data strobe
- BACT  in  1  CPU bus cycle active (AS asserted)
- IOCS  in  1  cycle targets IOB domain (from decoder)
- IOPWCS  in  1  cycle is post-write eligible (from decoder)
- CPUACK  out  1  terminate CPU cycle (feeds DTACK logic)
- IOREQ  out  1  IOB transaction request
- IOA  out  23  IOB address
- IOD  out  16  IOB write data
- IOnWE  out  1  IOB write strobe
- IOnUDS  out  1  IOB upper data strobe
- IOnLDS  out  1  IOB lower data strobe
- IOACK  in  1  one-cycle pulse: IOB transaction complete
- PWEmpty  out  1  FIFO empty
- PWFull  out  1  FIFO full

Behaviour:
- Reset values:
  - CPUACK=0, IOREQ=0, IOA=0, IOD=0.
  - IOnWE=1, IOnUDS=1, IOnLDS=1.
  - PWEmpty=1, PWFull=0.
  - FIFO count=0, both pointers=0, IO FSM=IDLE, Handled=0.
- Reset mid-operation: everything returns to reset values; FIFO contents are discarded.
- All outputs are registered.
- Handled flag:
  - Set when a cycle is accepted (posted enqueue, or direct completion).
  - Cleared in the cycle after BACT is sampled low.
  - Each CPU bus cycle is acted on at most once.
- CPUACK:
  - Set on acceptance.
  - Held while BACT=1.
  - Cleared the cycle after BACT=0.
- Posted path, when BACT && IOCS && IOPWCS && !nWE && !Handled:
  - If count<DEPTH at edge k: write {A,D,nUDS,nLDS} at the write pointer; CPUACK=1 from k+1.
  - If full: wait, CPU stalls, no CPUACK; enqueue on the first edge with count<DEPTH.
- Direct path, when BACT && IOCS && !Handled && not posted-eligible:
  - Sets DirPend.
  - IO FSM services it only when count==0.
  - On IOACK for the direct transaction: CPUACK=1 next cycle, DirPend cleared.
  - If BACT falls before completion (protocol violation): the IOB transaction still completes and CPUACK stays 0.
- Cycles with IOCS=0 are ignored entirely.
- IO FSM states: IDLE, POSTED, DIRECT.
  - IDLE -> POSTED when count>0: load IOA/IOD/strobes from the head entry, IOnWE=0, IOREQ=1.
  - IDLE -> DIRECT when count==0 && DirPend: load live A/D/nWE/strobes, IOREQ=1.
  - Posted takes priority over direct.
  - POSTED on IOACK: IOREQ=0, dequeue (read pointer +1), -> IDLE.
  - DIRECT on IOACK: IOREQ=0, -> IDLE.
  - Minimum one IDLE cycle between IOB transactions.
  - IOACK while in IDLE is ignored.
- Latency: for a posted write accepted at edge k into an empty FIFO, IOREQ=1 at k+2.
- FIFO arithmetic:
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - count is 0..DEPTH.
  - Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
  - PWEmpty = (count==0); PWFull = (count==DEPTH); both registered alongside count.
- IOA/IOD/strobes are held stable for the whole time IOREQ=1.

Decomposition:
- Shared package io_pkg:
  - PW_DEPTH_DEF=2.
  - typedef pw_entry_t {a[23:1], d[15:0], nuds, nlds} (41 bits).
  - enum io_state_t {IDLE, POSTED, DIRECT}.
- One sub-module, pw_fifo: synchronous FIFO parameterised by DEPTH, entry type pw_entry_t, with push/pop/head/count/empty/full, async active-low reset.
- The top level holds the CPU-side acceptance logic and the IO FSM.

Test Plan:
- Single posted write (A=3FA100>>1, D=1234, nUDS=nLDS=0) -> CPUACK at k+1; IOREQ at k+2 with IOA/IOD matching and IOnWE=0; IOACK -> PWEmpty=1.
- Three back-to-back posted writes, DEPTH=2, IOACK withheld -> first two acked, PWFull=1, third stalls (CPUACK=0); one IOACK -> third enqueues next edge and is acked.
- Posted write followed by an IOCS read (nWE=1) to E00000 -> read's IOREQ issues only after the posted entry's IOACK; CPUACK for the read follows its own IOACK.
- Simultaneous enqueue and IOACK dequeue with count=1 -> count stays 1, pointers wrap correctly over 4 iterations, data order preserved.
- nRES pulsed low mid-transaction with IOREQ=1 and count=2 -> IOREQ, CPUACK, count clear asynchronously; spurious IOACK afterwards is ignored.
- Non-IOCS cycle (A=000000, BACT=1) and IOACK in IDLE -> no IOREQ, no CPUACK, no state change.
